// File: rtl/proc_control.sv
// proc_control: instruction fetch and T0-T3 step sequencer driving register-file, bus and ALU controls.
module proc_control (
   input  logic        clock,
   input  logic        resetn,
   input  logic        run,
   input  logic [15:0] din,
   output logic [7:0]  rin,
   output logic [7:0]  rout,
   output logic        dinout,
   output logic        gout,
   output logic        ain,
   output logic        gin,
   output logic        sub,
   output logic        done,
   output logic [1:0]  tstep
);
   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
   step_t      step_q, step_d;
   logic [8:0] ir_q, ir_d;
   logic [2:0] op;
   logic [7:0] x_oh, y_oh;
   logic       is_alu;
   assign op     = ir_q[8:6];
   assign x_oh   = 8'b1 << ir_q[5:3];
   assign y_oh   = 8'b1 << ir_q[2:0];
   assign is_alu = op[2:1] == 2'b01;
   assign tstep  = step_q;
   always_comb begin
      step_d = step_q;
      ir_d   = ir_q;
      rin    = '0;
      rout   = '0;
      dinout = 1'b0;
      gout   = 1'b0;
      ain    = 1'b0;
      gin    = 1'b0;
      sub    = 1'b0;
      done   = 1'b0;
      case (step_q)
         T0: begin
            step_d = run ? T1 : T0;
            ir_d   = run ? din[8:0] : ir_q;
         end
         T1: begin
            step_d = is_alu ? T2 : T0;
            done   = !is_alu;
            ain    = is_alu;
            dinout = op == 3'b001;
            rin    = op[2:1] == 2'b00 ? x_oh : '0;
            rout   = op == 3'b000 ? y_oh : is_alu ? x_oh : '0;
         end
         T2: begin
            step_d = T3;
            rout   = y_oh;
            gin    = 1'b1;
            sub    = op[0];
         end
         T3: begin
            step_d = T0;
            gout   = 1'b1;
            rin    = x_oh;
            done   = 1'b1;
         end
         default: step_d = T0;
      endcase
   end
   // only add/sub can reach T2/T3, so those states need no opcode qualification
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         step_q <= T0;
         ir_q   <= '0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
      end
   end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: vector table plus scoreboard check of proc_control, with reset-abort sequence.
module tb_proc_control;
   logic        clock = 1'b0, resetn = 1'b0, run = 1'b0;
   logic [15:0] din = '0;
   logic [7:0]  rin, rout;
   logic        dinout, gout, ain, gin, sub, done;
   logic [1:0]  tstep;
   int          tests = 0, fails = 0;

   proc_control dut (
      .clock(clock), .resetn(resetn), .run(run), .din(din),
      .rin(rin), .rout(rout), .dinout(dinout), .gout(gout),
      .ain(ain), .gin(gin), .sub(sub), .done(done), .tstep(tstep)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        run;
      logic [15:0] din;
      logic [23:0] exp;
   } vec_t;

   vec_t        vecs[20];
   logic [23:0] sb[$];

   function automatic logic [23:0] e(input logic [7:0] ri, input logic [7:0] ro,
                                     input logic di, input logic go, input logic a,
                                     input logic g, input logic s, input logic d,
                                     input logic [1:0] t);
      return {ri, ro, di, go, a, g, s, d, t};
   endfunction

   function automatic logic [23:0] outs();
      return {rin, rout, dinout, gout, ain, gin, sub, done, tstep};
   endfunction

   task automatic check(input string n, input logic [23:0] act, input logic [23:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", n, act, req);
      end
   endtask

   task automatic invariants(input string n);
      check({n, "_bus_excl"}, {23'b0, ($countones(rout) + gout + dinout) <= 1}, 24'd1);
      check({n, "_onehot"}, {23'b0, $onehot0(rin) && $onehot0(rout)}, 24'd1);
   endtask

   initial begin
      logic [23:0] z;
      z = '0;
      vecs[0]  = '{1'b0, 16'h0000, z};
      vecs[1]  = '{1'b0, 16'h01FF, z};
      vecs[2]  = '{1'b1, 16'h0058, z};
      vecs[3]  = '{1'b1, 16'h00A5, e(8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1)};
      vecs[4]  = '{1'b0, 16'h0000, z};
      vecs[5]  = '{1'b1, 16'hFE0B, z};
      vecs[6]  = '{1'b0, 16'h0000, e(8'h02, 8'h08, 0, 0, 0, 0, 0, 1, 2'd1)};
      vecs[7]  = '{1'b1, 16'h0081, z};
      vecs[8]  = '{1'b1, 16'h01FF, e(8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 2'd1)};
      vecs[9]  = '{1'b1, 16'h01FF, e(8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 2'd2)};
      vecs[10] = '{1'b0, 16'h0000, e(8'h01, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3)};
      vecs[11] = '{1'b1, 16'h00D5, z};
      vecs[12] = '{1'b0, 16'h0000, e(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 2'd1)};
      vecs[13] = '{1'b0, 16'h0000, e(8'h00, 8'h20, 0, 0, 0, 1, 1, 0, 2'd2)};
      vecs[14] = '{1'b0, 16'h0000, e(8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3)};
      vecs[15] = '{1'b1, 16'h0100, z};
      vecs[16] = '{1'b1, 16'h0058, e(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1)};
      vecs[17] = '{1'b1, 16'h0058, z};
      vecs[18] = '{1'b0, 16'h00A5, e(8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1)};
      vecs[19] = '{1'b0, 16'h0000, z};

      repeat (2) @(posedge clock);
      #1 check("reset_hold", outs(), z);
      resetn = 1'b1;

      foreach (vecs[i]) begin
         run = vecs[i].run;
         din = vecs[i].din;
         sb.push_back(vecs[i].exp);
         check($sformatf("vec%0d", i), outs(), sb.pop_front());
         invariants($sformatf("vec%0d", i));
         @(posedge clock) #1;
      end

      // abort an add in T2 with an asynchronous reset
      run = 1'b1; din = 16'h0081;
      @(posedge clock) #1 run = 1'b0;
      @(posedge clock) #1 check("pre_abort_T2", outs(), e(8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 2'd2));
      #2 resetn = 1'b0;
      #1 check("async_reset", outs(), z);
      @(posedge clock) #1 check("reset_over_edge", outs(), z);
      #2 resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock) #1 check($sformatf("idle%0d", k), outs(), z);
      end

      run = 1'b1; din = 16'h000B;
      @(posedge clock) #1 run = 1'b0;
      check("post_reset_mv", outs(), e(8'h02, 8'h08, 0, 0, 0, 0, 0, 1, 2'd1));
      invariants("post_reset_mv");
      @(posedge clock) #1 check("post_reset_T0", outs(), z);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/proc_control.md
# proc_control

Instruction control unit for the structural CPU. It captures a 9-bit instruction from the 16-bit data input and steps through a 4-state timing sequence (T0–T3). From that state it drives the register-file load/drive enables, the bus-source selects and the ALU controls `ain`, `gin` and `sub`. It sits directly upstream of the ALU and the bus multiplexer: every control signal the ALU consumes is produced here.

## Interface

Parameters: none (data width fixed at 16, register count fixed at 8).

Ports:
- `clock`  in  1  single system clock; all state updates on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `run`  in  1  start request; sampled only in T0
- `din`  in  16  instruction word in T0, immediate data in T1 of `mvi`; IR captures `din[8:0]`, bits [15:9] ignored
- `rin`  out  8  one-hot register load enables, R0..R7
- `rout`  out  8  one-hot register bus-drive selects, R0..R7
- `dinout`  out  1  `din` drives the bus
- `gout`  out  1  ALU result register G drives the bus
- `ain`  out  1  ALU A register load
- `gin`  out  1  ALU G register load
- `sub`  out  1  ALU subtract (1) / add (0)
- `done`  out  1  final step of the current instruction
- `tstep`  out  2  current step (0=T0 … 3=T3), for debug/verification

## Operation

- IR fields: `op`=IR[8:6], `X`=IR[5:3] (destination), `Y`=IR[2:0] (source).
- Opcodes:
  - 000 `mv Rx,Ry`
  - 001 `mvi Rx,#D`
  - 010 `add Rx,Ry`
  - 011 `sub Rx,Ry`
  - 1xx reserved, executed as a no-op.
- Registers: `IR` (9 bits) and step counter (2 bits). All outputs are combinational decodes of step and IR.
- T0 (idle/fetch):
  - All outputs 0; `tstep`=0.
  - If `run`=1 at the edge: IR ← `din[8:0]`, go to T1. Otherwise stay in T0 and hold IR.
- T1:
  - `mv`: `rout[Y]`=1, `rin[X]`=1, `done`=1 → T0.
  - `mvi`: `dinout`=1, `rin[X]`=1, `done`=1 → T0.
  - `add`/`sub`: `rout[X]`=1, `ain`=1 → T2.
  - Reserved: `done`=1 only → T0.
- T2 (`add`/`sub` only): `rout[Y]`=1, `gin`=1, `sub`=(op==011) → T3.
- T3 (`add`/`sub` only): `gout`=1, `rin[X]`=1, `done`=1 → T0.
- Bus-exclusivity invariant: in every state, at most one of {any `rout` bit, `gout`, `dinout`} is 1. `rin` and `rout` are each zero or one-hot.
- `sub` is 1 only in T2 of a `sub` instruction; 0 everywhere else, including T1 and T3.
- `run` is ignored in T1–T3. An instruction always runs to completion unless reset.
- X==Y is legal. `mv R2,R2` drives and loads R2 in the same cycle; no special handling.

## Timing

- Reset (`resetn`=0, asynchronous): step ← T0 and IR ← 0 immediately, without waiting for a clock edge. All outputs are 0 while reset is held.
- Reset deasserts synchronously in effect: the first `run` sample is at the first rising edge with `resetn`=1.
- Latency from the `run` edge in T0:
  - `mv`/`mvi`/reserved: `done` in the next cycle; 2 cycles total.
  - `add`/`sub`: `done` in the 3rd cycle after the fetch edge; 4 cycles total.
- `done` is high for exactly one cycle per instruction.
- Back-to-back issue: after the `done` cycle the block is in T0. With `run` held high, the next instruction is fetched at that T0 edge, so there is no extra bubble beyond T0.
- Reset mid-instruction (e.g. in T2): the instruction is aborted, outputs go to 0 at once, and no `rin` pulse is generated.
- `mvi`: the upstream source must present the immediate on `din` during the T1 cycle.

## Test plan

- Reset: assert `resetn`=0 mid-T2 of an `add` → outputs immediately all 0, `tstep`=0; after release with `run`=0 → stays in T0 for 10 cycles.
- `mvi R3`: `din`=0x058 with `run`=1, then `din`=0x00A5 → T1 shows `rin`=0x08, `dinout`=1, `done`=1, `rout`=0; next cycle T0.
- `mv R1,R3`: `din`=0x00B → T1 `rout`=0x08, `rin`=0x02, `done`=1.
- `add R0,R1`: `din`=0x081 →
  - T1: `rout`=0x01, `ain`=1
  - T2: `rout`=0x02, `gin`=1, `sub`=0
  - T3: `gout`=1, `rin`=0x01, `done`=1
- `sub R2,R5`: `din`=0x0D5 → T2 `rout`=0x20, `gin`=1, `sub`=1; T3 `rin`=0x04. Check `sub`=0 in T1 and T3.
- Reserved and back-to-back: `din`=0x100 → T1 `done`=1 only. With `run` held, `mvi` follows with no bubble. Check bus exclusivity and one-hot `rin`/`rout` in every cycle.
